riscv_hwloop_state: RTL
=======================

Name: riscv_hwloop_state

Overview:
Hardware-loop register file and in-flight tracker. It is the producer side of the hwloop controller interface.
- Holds per-loop start address, end address and iteration counter, and presents them to the controller.
- Applies the controller's decrement requests to the counters.
- Tracks decrements issued in IF whose instruction has not yet left ID, and returns this as hwlp_dec_cnt_id_o.
- Sits in the ID stage, next to the controller. Written by lp.* setup instructions and CSR writes.

Parameters:
N_REGS, 2, number of hardware loops (1..4).
N_REG_BITS, $clog2(N_REGS) (min 1), width of the loop index; derived, not overridden.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
hwlp_start_data_i  input  32  start address write data
hwlp_end_data_i  input  32  end address write data
hwlp_cnt_data_i  input  32  counter write data
hwlp_we_i  input  3  write enables: [0]=start, [1]=end, [2]=counter
hwlp_regid_i  input  N_REG_BITS  loop index for writes
hwlp_dec_cnt_i  input  N_REGS  one-hot decrement request from the controller
if_fire_i  input  1  the IF instruction moves into ID this cycle
id_valid_i  input  1  the ID instruction moves into EX this cycle
flush_i  input  1  pipeline flush (branch, exception, debug)
hwlp_start_addr_o  output  N_REGS x 32  registered start addresses
hwlp_end_addr_o  output  N_REGS x 32  registered end addresses
hwlp_counter_o  output  N_REGS x 32  registered counters
hwlp_dec_cnt_id_o  output  N_REGS  decrement in flight between IF and ID
hwlp_active_o  output  N_REGS  counter != 0
hwlp_underflow_o  output  1  one-cycle pulse: decrement requested at counter 0

Behaviour:
- Reset (rst_n low, asynchronous): all start, end and counter registers are 0; dec_cnt_id flags are 0; underflow is 0; active_o is therefore 0.
- Writes:
  - Registered; the new value is visible on the outputs the next cycle.
  - Only the loop selected by hwlp_regid_i is written.
  - Any combination of the three enables may be set in one cycle.
  - If hwlp_regid_i >= N_REGS, the write is ignored.
- Address alignment: bit 0 of start and end is stored as 0. Bits [31:1] are stored unmodified.
- Decrement rule: counter[i] decrements by 1 when hwlp_dec_cnt_i[i] && if_fire_i. A request without if_fire_i has no effect.
- Counter floor:
  - A decrement at counter == 0 leaves the counter at 0; it never wraps.
  - In that case hwlp_underflow_o pulses high for exactly one cycle, registered (asserted the cycle after the request).
- Simultaneous events:
  - Counter write and decrement on the same loop: the write wins and the decrement is discarded.
  - A write to loop A and a decrement of loop B in the same cycle both take effect.
  - Multiple bits set in hwlp_dec_cnt_i: every flagged loop decrements (legal input is one-hot; the bench checks the one-hot assertion).
- In-flight flag, per loop i:
  - Set: hwlp_dec_cnt_i[i] && if_fire_i.
  - Clear: id_valid_i || flush_i.
  - Set has priority over clear in the same cycle, except under flush_i: flush clears unconditionally, including a same-cycle set.
  - Flush does not restore the counter; software re-arms the loop.
- hwlp_active_o[i] is combinational from the registered counter (counter[i] != 0).
- Latency: all register outputs are 1 cycle after the causing edge. No handshake stalls; the block accepts a write every cycle.
- Reset mid-operation: all state clears immediately. Pending decrements and flags are lost.

Decomposition:
- Shared package riscv_hwloop_pkg holds:
  - HWLP_WE_START/END/CNT bit indices (0/1/2).
  - The hwlp_we_t 3-bit typedef.
  - HWLP_MAX_REGS = 4.
- One natural sub-module, riscv_hwloop_lane: one loop's start/end/counter registers, write/decrement priority, in-flight flag and underflow detect.
- Top level: generate loop over N_REGS lanes, regid decode, and an OR reduction of the lane underflow signals into hwlp_underflow_o.

Test Plan:
1. Reset with outputs poisoned, then rst_n low mid-cycle → all outputs 0 asynchronously. After release: counters 0, active 0.
2. Write loop 1 with start=0x1001, end=0x2003, cnt=5, we=3'b111 → next cycle: start[1]=0x1000, end[1]=0x2002, counter[1]=5, active_o=2'b10. Loop 0 unchanged.
3. counter[0]=2; dec_cnt_i=2'b01 with if_fire_i for 2 consecutive cycles → counter 1 then 0, active_o[0] falls. A third decrement → counter stays 0 and underflow pulses once.
4. Same cycle: counter write of 7 to loop 0 and dec_cnt_i[0] with if_fire_i → counter[0]=7, not 6. A parallel dec_cnt_i[1] still decrements loop 1.
5. In-flight flag:
   - dec_cnt_i[0] with if_fire_i, id_valid_i=0 → dec_cnt_id_o[0]=1; stays 1 through 3 stall cycles; clears the cycle after id_valid_i.
   - New set concurrent with id_valid_i → flag stays 1.
6. Flag set, then flush_i concurrent with a new set → flag 0 next cycle. Counter keeps its decremented value.

Source files
------------

// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop register file.
package riscv_hwloop_pkg;

  localparam int HWLP_MAX_REGS  = 4;

  localparam int HWLP_WE_START  = 0;
  localparam int HWLP_WE_END    = 1;
  localparam int HWLP_WE_CNT    = 2;

  typedef logic [2:0] hwlp_we_t;

  // One lane's write request after regid decode.
  typedef struct packed {
    hwlp_we_t    we;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
    logic [31:0] cnt;
  } hwlp_wr_t;

  // Addresses are halfword aligned; bit 0 is never stored.
  function automatic logic [31:0] hwlp_align(input logic [31:0] addr);
    return addr & ~32'h1;
  endfunction

endpackage

// File: rtl/riscv_hwloop_lane.sv
// One hardware loop: start/end/counter registers, write-over-decrement
// priority, IF->ID in-flight flag and counter underflow detection.
module riscv_hwloop_lane
  import riscv_hwloop_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  hwlp_wr_t    wr_i,
  input  logic        dec_i,       // decrement request already qualified by if_fire
  input  logic        id_valid_i,
  input  logic        flush_i,
  output logic [31:0] start_o,
  output logic [31:0] end_o,
  output logic [31:0] cnt_o,
  output logic        dec_id_o,
  output logic        underflow_o
);

  logic [31:0] start_q, start_d;
  logic [31:0] end_q,   end_d;
  logic [31:0] cnt_q,   cnt_d;
  logic        dec_id_q, dec_id_d;
  logic        uf_q,     uf_d;

  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    uf_d    = 1'b0;

    if (wr_i.we[HWLP_WE_START]) start_d = hwlp_align(wr_i.start_addr);
    if (wr_i.we[HWLP_WE_END])   end_d   = hwlp_align(wr_i.end_addr);

    // A counter write discards a same-cycle decrement, including its underflow.
    if (wr_i.we[HWLP_WE_CNT]) begin
      cnt_d = wr_i.cnt;
    end else if (dec_i) begin
      if (cnt_q == 32'd0) uf_d  = 1'b1;
      else                cnt_d = cnt_q - 32'd1;
    end
  end

  // Flush beats everything; otherwise a new set beats the ID-side clear.
  always_comb begin
    dec_id_d = dec_id_q;
    if (flush_i)         dec_id_d = 1'b0;
    else if (dec_i)      dec_id_d = 1'b1;
    else if (id_valid_i) dec_id_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= '0;
      end_q    <= '0;
      cnt_q    <= '0;
      dec_id_q <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      start_q  <= start_d;
      end_q    <= end_d;
      cnt_q    <= cnt_d;
      dec_id_q <= dec_id_d;
      uf_q     <= uf_d;
    end
  end

  assign start_o     = start_q;
  assign end_o       = end_q;
  assign cnt_o       = cnt_q;
  assign dec_id_o    = dec_id_q;
  assign underflow_o = uf_q;

endmodule

// File: rtl/riscv_hwloop_state.sv
// Hardware-loop register file and IF->ID decrement tracker feeding the
// hwloop controller. One lane per loop; writes are steered by hwlp_regid_i.
module riscv_hwloop_state
  import riscv_hwloop_pkg::*;
#(
  parameter  int N_REGS     = 2,
  localparam int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              hwlp_start_data_i,
  input  logic [31:0]              hwlp_end_data_i,
  input  logic [31:0]              hwlp_cnt_data_i,
  input  logic [2:0]               hwlp_we_i,
  input  logic [N_REG_BITS-1:0]    hwlp_regid_i,
  input  logic [N_REGS-1:0]        hwlp_dec_cnt_i,
  input  logic                     if_fire_i,
  input  logic                     id_valid_i,
  input  logic                     flush_i,
  output logic [N_REGS-1:0][31:0]  hwlp_start_addr_o,
  output logic [N_REGS-1:0][31:0]  hwlp_end_addr_o,
  output logic [N_REGS-1:0][31:0]  hwlp_counter_o,
  output logic [N_REGS-1:0]        hwlp_dec_cnt_id_o,
  output logic [N_REGS-1:0]        hwlp_active_o,
  output logic                     hwlp_underflow_o
);

  logic [N_REGS-1:0] lane_dec;
  logic [N_REGS-1:0] lane_uf;

  assign lane_dec = hwlp_dec_cnt_i & {N_REGS{if_fire_i}};

  for (genvar i = 0; i < N_REGS; i++) begin : g_lane
    hwlp_wr_t wr;

    // Regid values at or above N_REGS match no lane, so the write is dropped.
    always_comb begin
      wr            = '0;
      wr.start_addr = hwlp_start_data_i;
      wr.end_addr   = hwlp_end_data_i;
      wr.cnt        = hwlp_cnt_data_i;
      if (hwlp_regid_i == N_REG_BITS'(i)) wr.we = hwlp_we_i;
    end

    riscv_hwloop_lane u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_i        (wr),
      .dec_i       (lane_dec[i]),
      .id_valid_i  (id_valid_i),
      .flush_i     (flush_i),
      .start_o     (hwlp_start_addr_o[i]),
      .end_o       (hwlp_end_addr_o[i]),
      .cnt_o       (hwlp_counter_o[i]),
      .dec_id_o    (hwlp_dec_cnt_id_o[i]),
      .underflow_o (lane_uf[i])
    );

    assign hwlp_active_o[i] = |hwlp_counter_o[i];
  end

  assign hwlp_underflow_o = |lane_uf;

endmodule
